// File: rtl/cla32_pipe_if.sv
// Handshake and data bundle for the two-stage 32-bit carry-lookahead adder.
// The upstream/downstream environment uses master; the adder uses slave.
interface cla32_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        co;
  logic        ovf;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/cla32_pipe.sv
// 32-bit adder built from eight 4-bit carry-lookahead slices split into two
// valid/ready pipeline stages: low 16 bits in stage 1, high 16 bits in stage 2.
module cla32_pipe (
  input  logic        clk,
  input  logic        reset_n,
  cla32_pipe_if.slave bus
);

  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;
    g     = x & y;
    p     = x ^ y;
    cc[0] = c;
    cc[1] = g[0] | (p[0] & c);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    return {cc[4], p ^ cc[3:0]};
  endfunction

  // Stage-1 state
  logic        v1_q, v1_d;
  logic [15:0] lo_sum_q, lo_sum_d;
  logic        c16_q, c16_d;
  logic [15:0] a_hi_q, a_hi_d;
  logic [15:0] b_hi_q, b_hi_d;
  logic        a31_q, a31_d;
  logic        b31_q, b31_d;

  // Stage-2 state
  logic        v2_q, v2_d;
  logic [31:0] s_q, s_d;
  logic        co_q, co_d;
  logic        ovf_q, ovf_d;

  logic        adv1, adv2;
  logic [4:0]  carry1;
  logic [4:0]  carry2;
  logic [15:0] sum1;
  logic [15:0] sum2;

  assign carry1[0] = bus.ci;
  assign carry2[0] = c16_q;

  // Slices 0-3 ripple on the live inputs, slices 4-7 on the stage-1 registers.
  for (genvar i = 0; i < 4; i++) begin : g_slices
    assign {carry1[i+1], sum1[4*i +: 4]} = cla4(bus.a[4*i +: 4], bus.b[4*i +: 4], carry1[i]);
    assign {carry2[i+1], sum2[4*i +: 4]} = cla4(a_hi_q[4*i +: 4], b_hi_q[4*i +: 4], carry2[i]);
  end

  assign adv2 = !v2_q || bus.out_ready;
  assign adv1 = !v1_q || adv2;

  always_comb begin
    v1_d     = v1_q;
    lo_sum_d = lo_sum_q;
    c16_d    = c16_q;
    a_hi_d   = a_hi_q;
    b_hi_d   = b_hi_q;
    a31_d    = a31_q;
    b31_d    = b31_q;
    if (adv1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        lo_sum_d = sum1;
        c16_d    = carry1[4];
        a_hi_d   = bus.a[31:16];
        b_hi_d   = bus.b[31:16];
        a31_d    = bus.a[31];
        b31_d    = bus.b[31];
      end
    end
  end

  always_comb begin
    v2_d  = v2_q;
    s_d   = s_q;
    co_d  = co_q;
    ovf_d = ovf_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s_d   = {sum2, lo_sum_q};
        co_d  = carry2[4];
        ovf_d = (a31_q == b31_q) && (sum2[15] != a31_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      lo_sum_q <= '0;
      c16_q    <= 1'b0;
      a_hi_q   <= '0;
      b_hi_q   <= '0;
      a31_q    <= 1'b0;
      b31_q    <= 1'b0;
      v2_q     <= 1'b0;
      s_q      <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      lo_sum_q <= lo_sum_d;
      c16_q    <= c16_d;
      a_hi_q   <= a_hi_d;
      b_hi_q   <= b_hi_d;
      a31_q    <= a31_d;
      b31_q    <= b31_d;
      v2_q     <= v2_d;
      s_q      <= s_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  // Empty pipeline would otherwise advertise ready while held in reset.
  assign bus.in_ready  = reset_n && adv1;
  assign bus.out_valid = v2_q;
  assign bus.s         = s_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla32_pipe.sv
// Scoreboard bench for cla32_pipe: expected {ovf,co,s} queued on input transfer,
// popped and compared on output transfer.
module tb_cla32_pipe;

  logic clk = 1'b0;
  logic reset_n;
  cla32_pipe_if bus ();

  cla32_pipe dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [33:0] exp_q[$];
  logic [33:0] e;
  bit          ix, ox;
  logic        ir, ov;
  logic [33:0] got;

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] t;
    t = {1'b0, x} + {1'b0, y} + {32'b0, c};
    return {(x[31] == y[31]) && (t[31] != x[31]), t[32], t[31:0]};
  endfunction

  // One clock: sample at negedge, log accepted input, return just after posedge.
  task automatic cyc();
    @(negedge clk);
    ir  = bus.in_ready;
    ov  = bus.out_valid;
    got = {bus.ovf, bus.co, bus.s};
    ix  = bus.in_valid && ir;
    ox  = ov && bus.out_ready;
    if (ix) exp_q.push_back(model(bus.a, bus.b, bus.ci));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if ({bus.ovf, bus.co, bus.s} !== 34'h0) begin fails++; $display("FAIL rst_outputs got=%h exp=0", {bus.ovf, bus.co, bus.s}); end
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_hold_in_ready got=%b exp=0", bus.in_ready); end
    reset_n = 1'b1;
    cyc();
    tests++; if (ir !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got=%b exp=1", ir); end
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL rst_release_out_valid got=%b exp=0", ov); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.a = 32'h0000_FFFF; bus.b = 32'h0000_0001; bus.ci = 1'b0; bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin
        bus.in_valid = 1'b0;
        tests++; if (ix !== 1'b1) begin fails++; $display("FAIL single_accept got=%b exp=1", ix); end
      end
      tests++;
      if (ox !== (k == 2)) begin fails++; $display("FAIL single_latency cycle=%0d got=%b exp=%b", k, ox, k == 2); end
      if (ox) begin
        tests++;
        if (got !== 34'h0_0001_0000) begin fails++; $display("FAIL single_result got=%h exp=%h", got, 34'h0_0001_0000); end
        if (exp_q.size() != 0) e = exp_q.pop_front();
      end
    end
  endtask

  task automatic test_wrap();
    logic [33:0] want [2];
    int n = 0;
    want[0] = {1'b0, 1'b1, 32'h0000_0000};
    want[1] = {1'b1, 1'b0, 32'h8000_0000};
    bus.out_ready = 1'b1;
    bus.a = 32'hFFFF_FFFF; bus.b = 32'h0; bus.ci = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 0) begin bus.a = 32'h7FFF_FFFF; bus.b = 32'h1; bus.ci = 1'b0; end
      if (k == 1) bus.in_valid = 1'b0;
      if (ox) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        tests++;
        if (n < 2 && got !== want[n]) begin fails++; $display("FAIL wrap_result%0d got=%h exp=%h", n, got, want[n]); end
        n++;
      end
    end
    tests++; if (n != 2) begin fails++; $display("FAIL wrap_count got=%0d exp=2", n); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.ci = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.in_valid = (k < 8);
      bus.a = 32'(k + 1);
      bus.b = 32'(16 * (k + 1));
      cyc();
      if (k < 8) begin
        tests++; if (ir !== 1'b1) begin fails++; $display("FAIL b2b_in_ready cycle=%0d got=%b exp=1", k, ir); end
      end
      tests++;
      if (ox !== (k >= 2 && k <= 9)) begin fails++; $display("FAIL b2b_out_timing cycle=%0d got=%b exp=%b", k, ox, k >= 2 && k <= 9); end
      if (ox) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_extra got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin fails++; $display("FAIL b2b_result got=%h exp=%h", got, e); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [33:0] held;
    int idx = 0;
    int nres = 0;
    pa[0] = 32'h1234_5678; pb[0] = 32'h1111_1111;
    pa[1] = 32'h8000_0000; pb[1] = 32'h8000_0000;
    pa[2] = 32'hDEAD_BEEF; pb[2] = 32'h2152_4111;
    held = '0;
    bus.out_ready = 1'b0;
    bus.ci = 1'b0;
    bus.a = pa[0]; bus.b = pb[0]; bus.in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) bus.out_ready = 1'b1;
      cyc();
      if (k == 2) begin
        held = exp_q[0];
        tests++; if (ir !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full got=%b exp=0", ir); end
        tests++; if (ov !== 1'b1) begin fails++; $display("FAIL bp_out_valid got=%b exp=1", ov); end
        tests++; if (got !== held) begin fails++; $display("FAIL bp_hold_op1 got=%h exp=%h", got, held); end
      end
      if (k == 3) begin
        tests++; if (got !== held) begin fails++; $display("FAIL bp_stable got=%h exp=%h", got, held); end
      end
      if (ix) begin
        idx++;
        if (idx < 3) begin bus.a = pa[idx]; bus.b = pb[idx]; end
        else bus.in_valid = 1'b0;
      end
      if (ox) begin
        nres++;
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL bp_extra got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin fails++; $display("FAIL bp_result got=%h exp=%h", got, e); end
        end
      end
    end
    tests++; if (nres != 3) begin fails++; $display("FAIL bp_count got=%0d exp=3", nres); end
    tests++; if (idx != 3) begin fails++; $display("FAIL bp_accepted got=%0d exp=3", idx); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.a = 32'hAAAA_AAAA; bus.b = 32'h5555_5555; bus.ci = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      tests++; if (ix !== 1'b1) begin fails++; $display("FAIL rm_accept%0d got=%b exp=1", k, ix); end
    end
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rm_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.s !== 32'h0) begin fails++; $display("FAIL rm_s got=%h exp=0", bus.s); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rm_in_ready got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rm_release_ready got=%b exp=1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL rm_stale cycle=%0d got=%b exp=0", k, ov); end
    end
  endtask

  task automatic test_random();
    int n_ops = 10000;
    int sent = 0;
    int recv = 0;
    for (int c = 0; c < 40000 && recv < n_ops; c++) begin
      bus.in_valid  = (sent < n_ops) && ($urandom_range(0, 3) != 0);
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.ci        = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      if (ix) sent++;
      if (ox) begin
        recv++;
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL rnd_extra got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin fails++; $display("FAIL rnd_result got=%h exp=%h", got, e); end
        end
      end
    end
    bus.in_valid = 1'b0;
    tests++; if (recv != n_ops) begin fails++; $display("FAIL rnd_timeout got=%0d exp=%0d", recv, n_ops); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
